// File: rtl/debug_event_queue.sv
// Event FIFO feeding the debug serial sender. It buffers 40-bit tag/payload events
// and hands them out one word at a time with a latch pulse, paced by the sender's busy line.
module debug_event_queue #(
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ev_valid,
    input  logic [7:0]    ev_tag,
    input  logic [31:0]   ev_data,
    input  logic          sender_busy,
    output logic [39:0]   out_data,
    output logic          out_latch,
    output logic [AW:0]   level,
    output logic [7:0]    drop_count,
    output logic          sender_timeout
);

    localparam int            CW          = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_MAX = CW'(ACK_TIMEOUT);
    localparam logic [AW:0]   FULL_LEVEL  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        WAIT_FALL
    } state_e;

    state_e         state_q;
    logic [39:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    level_q, level_d;
    logic [7:0]     drop_q, drop_d;
    logic           busy_meta_q, busy_s_q;
    logic [CW-1:0]  cnt_q;
    logic [39:0]    out_data_q;
    logic           out_latch_q;
    logic           timeout_q;
    logic           rd_en;
    logic           wr_en;

    assign rd_en = (state_q == IDLE) && (level_q != '0) && !busy_s_q;
    // A full FIFO still takes a write in the same cycle its head is popped.
    assign wr_en = ev_valid && ((level_q != FULL_LEVEL) || rd_en);

    // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        drop_d   = drop_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
        if (ev_valid && !wr_en && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    // NOTE: storage is not reset; the pointers and level alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {ev_tag, ev_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
        end else begin
            busy_meta_q <= sender_busy;
            busy_s_q    <= busy_meta_q;
        end
    end

    // Handshake FSM: the word is popped at latch time and never resent, even after a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_latch_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            out_latch_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rd_en) begin
                        out_data_q  <= mem_q[rd_ptr_q];
                        out_latch_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (busy_s_q) begin
                        state_q <= WAIT_FALL;
                    end else if (cnt_q == TIMEOUT_MAX) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                WAIT_FALL: begin
                    if (!busy_s_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data       = out_data_q;
    assign out_latch      = out_latch_q;
    assign level          = level_q;
    assign drop_count     = drop_q;
    assign sender_timeout = timeout_q;

endmodule

// File: tb/tb_debug_event_queue.sv
// Directed bench for debug_event_queue: a per-cycle vector table for the basic handshake,
// then hand-written sequences for bursts, drops, timeout, full-FIFO push and mid-transfer reset.
module tb_debug_event_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        ev_valid;
    logic [7:0]  ev_tag;
    logic [31:0] ev_data;
    logic        sender_busy;
    logic [39:0] out_data;
    logic        out_latch;
    logic [3:0]  level;
    logic [7:0]  drop_count;
    logic        sender_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int latch_cnt = 0;

    debug_event_queue #(.DEPTH(8), .AW(3), .ACK_TIMEOUT(255)) dut (
        .clk            (clk),
        .reset          (reset),
        .ev_valid       (ev_valid),
        .ev_tag         (ev_tag),
        .ev_data        (ev_data),
        .sender_busy    (sender_busy),
        .out_data       (out_data),
        .out_latch      (out_latch),
        .level          (level),
        .drop_count     (drop_count),
        .sender_timeout (sender_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (out_latch === 1'b1) latch_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ev;
        logic [7:0]  tag;
        logic [31:0] data;
        logic        busy;
        logic        exp_latch;
        logic [3:0]  exp_level;
        logic [39:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic ev, input logic [7:0] tag, input logic [31:0] data,
                       input logic busy, input logic exp_latch, input logic [3:0] exp_level,
                       input logic [39:0] exp_data);
        vec_t v;
        v.ev = ev; v.tag = tag; v.data = data; v.busy = busy;
        v.exp_latch = exp_latch; v.exp_level = exp_level; v.exp_data = exp_data;
        vecs.push_back(v);
    endtask

    // Leaves reset deasserted just after a falling edge; sender_busy is left to the caller.
    task automatic do_reset(input string name);
        @(negedge clk);
        reset    = 1'b1;
        ev_valid = 1'b0;
        @(posedge clk); #1;
        check({name, " level"},   64'(level),          64'd0);
        check({name, " latch"},   64'(out_latch),      64'd0);
        check({name, " data"},    64'(out_data),       64'd0);
        check({name, " drops"},   64'(drop_count),     64'd0);
        check({name, " timeout"}, 64'(sender_timeout), 64'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input logic [7:0] tag, input logic [31:0] data);
        @(negedge clk);
        ev_valid = 1'b1;
        ev_tag   = tag;
        ev_data  = data;
    endtask

    // Sender model: wait (bounded) for a latch, check the word, then pulse busy.
    task automatic serve(input logic [39:0] exp, input string name);
        int n;
        n = 0;
        while (out_latch !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latch"}, 64'(out_latch), 64'd1);
        check({name, " data"},  64'(out_data),  64'(exp));
        @(negedge clk);
        sender_busy = 1'b1;
        repeat (6) @(negedge clk);
        sender_busy = 1'b0;
    endtask

    initial begin
        int base;
        logic [39:0] w_a, w_b1, w_b2, w_z, w_x, w_y;
        reset = 1'b0; ev_valid = 1'b0; ev_tag = '0; ev_data = '0; sender_busy = 1'b0;

        do_reset("reset");

        // Single event (sender answers 3 cycles after latch, holds 20), then a write+read at level 1.
        w_a  = 40'hA9_99999991;
        w_b1 = 40'h01_00000011;
        w_b2 = 40'h02_00000022;
        add(1, 8'hA9, 32'h99999991, 0, 0, 1, 40'h0);
        add(0, 8'h00, 32'h0,        0, 1, 0, w_a);
        for (int i = 0; i < 2;  i++) add(0, 8'h00, 32'h0, 0, 0, 0, w_a);
        for (int i = 0; i < 20; i++) add(0, 8'h00, 32'h0, 1, 0, 0, w_a);
        for (int i = 0; i < 6;  i++) add(0, 8'h00, 32'h0, 0, 0, 0, w_a);
        add(1, 8'h01, 32'h00000011, 0, 0, 1, w_a);
        add(1, 8'h02, 32'h00000022, 0, 1, 1, w_b1);
        add(0, 8'h00, 32'h0,        0, 0, 1, w_b1);
        for (int i = 0; i < 2; i++) add(0, 8'h00, 32'h0, 1, 0, 1, w_b1);
        for (int i = 0; i < 3; i++) add(0, 8'h00, 32'h0, 0, 0, 1, w_b1);
        add(0, 8'h00, 32'h0, 0, 1, 0, w_b2);
        add(0, 8'h00, 32'h0, 0, 0, 0, w_b2);

        foreach (vecs[i]) begin
            @(negedge clk);
            ev_valid    = vecs[i].ev;
            ev_tag      = vecs[i].tag;
            ev_data     = vecs[i].data;
            sender_busy = vecs[i].busy;
            @(posedge clk); #1;
            check($sformatf("vec%0d latch", i), 64'(out_latch),      64'(vecs[i].exp_latch));
            check($sformatf("vec%0d level", i), 64'(level),          64'(vecs[i].exp_level));
            check($sformatf("vec%0d data", i),  64'(out_data),       64'(vecs[i].exp_data));
            check($sformatf("vec%0d drops", i), 64'(drop_count),     64'd0);
            check($sformatf("vec%0d tmo", i),   64'(sender_timeout), 64'd0);
        end

        // Burst of 8 while busy, then a push in the exact latch cycle of a full FIFO.
        do_reset("reset2");
        sender_busy = 1'b1;
        repeat (3) @(negedge clk);
        base = latch_cnt;
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 32'hC000_0000 + 32'(i));
        @(negedge clk);
        ev_valid = 1'b0;
        check("burst8 level", 64'(level),      64'd8);
        check("burst8 drops", 64'(drop_count), 64'd0);
        check("burst8 no latch", 64'(latch_cnt - base), 64'd0);
        sender_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        w_z = 40'h5A_DEADBEEF;
        ev_valid = 1'b1; ev_tag = 8'h5A; ev_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("fullpush latch", 64'(out_latch),  64'd1);
        check("fullpush data",  64'(out_data),   64'h10_C0000000);
        check("fullpush level", 64'(level),      64'd8);
        check("fullpush drops", 64'(drop_count), 64'd0);
        @(negedge clk);
        ev_valid    = 1'b0;
        sender_busy = 1'b1;
        repeat (6) @(negedge clk);
        sender_busy = 1'b0;
        for (int i = 1; i < 8; i++)
            serve({8'h10 + 8'(i), 32'hC000_0000 + 32'(i)}, $sformatf("burst word%0d", i));
        serve(w_z, "pushed word");
        repeat (20) @(negedge clk);
        check("burst latch count", 64'(latch_cnt - base), 64'd9);
        check("burst drained",     64'(level),             64'd0);

        // Overflow: 11 into an empty queue with sender busy, then 300 more drops.
        do_reset("reset3");
        sender_busy = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 11; i++) push(8'h20, 32'(i));
        @(negedge clk);
        ev_valid = 1'b0;
        check("ovf11 level", 64'(level),      64'd8);
        check("ovf11 drops", 64'(drop_count), 64'd3);
        for (int i = 0; i < 300; i++) push(8'h21, 32'(i));
        @(negedge clk);
        ev_valid = 1'b0;
        check("ovf sat drops", 64'(drop_count), 64'd255);
        check("ovf sat level", 64'(level),      64'd8);

        // Sender never answers: first word abandoned after 256 cycles, second latches 1 cycle later.
        sender_busy = 1'b0;
        do_reset("reset4");
        w_x = 40'h31_11111111;
        w_y = 40'h32_22222222;
        push(8'h31, 32'h11111111);
        @(posedge clk); #1;
        push(8'h32, 32'h22222222);
        @(posedge clk); #1;
        check("tmo first latch", 64'(out_latch), 64'd1);
        check("tmo first data",  64'(out_data),  64'(w_x));
        @(negedge clk);
        ev_valid = 1'b0;
        repeat (255) @(posedge clk);
        #1;
        check("tmo not yet", 64'(sender_timeout), 64'd0);
        @(posedge clk); #1;
        check("tmo set",      64'(sender_timeout), 64'd1);
        check("tmo no latch", 64'(out_latch),      64'd0);
        @(posedge clk); #1;
        check("tmo next latch", 64'(out_latch), 64'd1);
        check("tmo next data",  64'(out_data),  64'(w_y));
        check("tmo level",      64'(level),     64'd0);
        repeat (300) @(posedge clk);
        #1;
        check("tmo sticky", 64'(sender_timeout), 64'd1);
        check("tmo held data", 64'(out_data),    64'(w_y));

        // Reset while in WAIT_FALL with five words queued.
        do_reset("reset5");
        for (int i = 0; i < 6; i++) push(8'h40 + 8'(i), 32'(i));
        @(negedge clk);
        ev_valid    = 1'b0;
        sender_busy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst level before", 64'(level), 64'd5);
        do_reset("midrst");
        sender_busy = 1'b0;
        base = latch_cnt;
        repeat (10) @(negedge clk);
        check("midrst no latch", 64'(latch_cnt - base), 64'd0);
        check("midrst level",    64'(level),            64'd0);
        ev_valid = 1'b1; ev_tag = 8'h77; ev_data = 32'h12345678;
        @(posedge clk); #1;
        check("midrst new level", 64'(level), 64'd1);
        @(negedge clk);
        ev_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst new latch", 64'(out_latch), 64'd1);
        check("midrst new data",  64'(out_data),  64'h77_12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
